// File: rtl/vecmac_pkg.sv
// Shared widths, FSM encodings and saturation bounds for the int8 vector MAC pipeline.
// Pure constants and constant functions; no logic, latency or backpressure of its own.
package vecmac_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

  function automatic int clog2_f(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Width of the reduced lane sum: one product (2*DW+1) plus growth per tree level.
  function automatic int tree_w(input int lanes, input int dw);
    return 2*dw + 1 + clog2_f(lanes);
  endfunction

  function automatic logic [127:0] smax_f(input int w);
    return (128'd1 << (w-1)) - 128'd1;
  endfunction

  function automatic logic [127:0] smin_f(input int w);
    return ~smax_f(w);
  endfunction

  function automatic logic [127:0] umax_f(input int w);
    return (128'd1 << w) - 128'd1;
  endfunction

endpackage

// File: rtl/vecmac_adder_tree.sv
// Pairwise sign-extending reduction of LANES products, one register at the output.
// Latency 1 clk when en=1; holds its output while en=0.
module vecmac_adder_tree
  import vecmac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int PW    = 17,
  localparam int LV   = clog2_f(LANES),
  localparam int TW   = PW + LV
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [LANES*PW-1:0] in_dat,
  output logic [TW-1:0]      out_sum
);

  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    logic [(LANES>>l)-1:0][TW-1:0] n;
    if (l == 0) begin : g_leaf
      // Unsigned products never set bit PW-1, so sign extension is safe in both modes.
      for (genvar k = 0; k < LANES; k++) begin : g_k
        assign n[k] = {{(TW-PW){in_dat[k*PW+PW-1]}}, in_dat[k*PW +: PW]};
      end
    end else begin : g_sum
      for (genvar k = 0; k < (LANES>>l); k++) begin : g_k
        assign n[k] = g_lvl[l-1].n[2*k] + g_lvl[l-1].n[2*k+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum <= '0;
    end else if (en) begin
      out_sum <= g_lvl[LV].n[0];
    end
  end

endmodule

// File: rtl/vecmac_acc_pipe.sv
// Int8 vector MAC: lane multiply, adder tree, saturating multi-beat accumulate, one result per vector.
// Last beat to out_valid is 3 clk; a pending unconsumed result stalls the whole pipe and drops in_ready.
module vecmac_acc_pipe
  import vecmac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 32
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_a,
  input  logic [LANES*DW-1:0] in_b,
  input  logic                in_signed,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_acc,
  output logic                out_sat
);

  localparam int PW = 2*DW + 1;
  localparam int TW = tree_w(LANES, DW);
  localparam int XW = ((ACC_W > TW) ? ACC_W : TW) + 2;
  localparam logic signed [XW-1:0] SMAX_X = XW'(smax_f(ACC_W));
  localparam logic signed [XW-1:0] SMIN_X = XW'(smin_f(ACC_W));
  localparam logic signed [XW-1:0] UMAX_X = XW'(umax_f(ACC_W));

  logic en, take;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign take     = in_valid && en;

  // Mode is latched on the first beat of a vector and rides with every later beat.
  logic first_q, mode_q, beat_mode;
  assign beat_mode = first_q ? in_signed : mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      mode_q  <= 1'b0;
    end else if (take) begin
      first_q <= in_last;
      if (first_q) mode_q <= in_signed;
    end
  end

  logic [LANES*PW-1:0] prod;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW:0] a_x, b_x;
    (* use_dsp = "no" *) logic [2*DW+1:0] p_full;
    assign a_x    = {beat_mode & in_a[i*DW+DW-1], in_a[i*DW +: DW]};
    assign b_x    = {beat_mode & in_b[i*DW+DW-1], in_b[i*DW +: DW]};
    assign p_full = {{(DW+1){a_x[DW]}}, a_x} * {{(DW+1){b_x[DW]}}, b_x};
    assign prod[i*PW +: PW] = p_full[PW-1:0];
  end

  logic                s1_vld, s1_last, s1_mode;
  logic [LANES*PW-1:0] s1_prod;
  logic                s2_vld, s2_last, s2_mode;
  logic [TW-1:0]       s2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_mode <= 1'b0;
      s1_prod <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_mode <= 1'b0;
    end else if (en) begin
      s1_vld  <= take;
      s1_last <= in_last;
      s1_mode <= beat_mode;
      s1_prod <= prod;
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      s2_mode <= s1_mode;
    end
  end

  vecmac_adder_tree #(.LANES(LANES), .PW(PW)) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .in_dat  (s1_prod),
    .out_sum (s2_sum)
  );

  logic [1:0]        state;
  logic [ACC_W-1:0]  acc, nxt;
  logic              sat, step_sat;
  logic [XW-1:0]     acc_x, sum_x;
  logic signed [XW-1:0] tot;

  assign acc_x = s2_mode ? {{(XW-ACC_W){acc[ACC_W-1]}}, acc} : {{(XW-ACC_W){1'b0}}, acc};
  assign sum_x = {{(XW-TW){s2_sum[TW-1]}}, s2_sum};
  assign tot   = signed'(acc_x + sum_x);

  always_comb begin
    nxt      = tot[ACC_W-1:0];
    step_sat = 1'b0;
    if (s2_mode) begin
      if (tot > SMAX_X) begin
        nxt = SMAX_X[ACC_W-1:0]; step_sat = 1'b1;
      end else if (tot < SMIN_X) begin
        nxt = SMIN_X[ACC_W-1:0]; step_sat = 1'b1;
      end
    end else if (tot[XW-1]) begin
      nxt = '0; step_sat = 1'b1;
    end else if (tot > UMAX_X) begin
      nxt = UMAX_X[ACC_W-1:0]; step_sat = 1'b1;
    end
  end

  // With en=1 any held result is being consumed this cycle, so out_valid may drop unless reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      if (s2_vld && s2_last) begin
        state     <= ST_EMIT;
        out_valid <= 1'b1;
        out_acc   <= nxt;
        out_sat   <= sat | step_sat;
        acc       <= '0;
        sat       <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        if (s2_vld) begin
          state <= ST_ACCUM;
          acc   <= nxt;
          sat   <= sat | step_sat;
        end else if (state == ST_EMIT) begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vecmac_acc_pipe.sv
// Scoreboard bench for vecmac_acc_pipe: a 32-bit accumulator instance and an 18-bit one for saturation.
`timescale 1ns/1ps
module tb_vecmac_acc_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_in_signed, a_in_last, a_out_valid, a_out_ready, a_out_sat;
  logic [31:0] a_in_a, a_in_b, a_out_acc;
  logic        b_in_valid, b_in_ready, b_in_signed, b_in_last, b_out_valid, b_out_ready, b_out_sat;
  logic [31:0] b_in_a, b_in_b;
  logic [17:0] b_out_acc;

  vecmac_acc_pipe #(.LANES(4), .DW(8), .ACC_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_a(a_in_a), .in_b(a_in_b), .in_signed(a_in_signed), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_acc(a_out_acc), .out_sat(a_out_sat)
  );

  vecmac_acc_pipe #(.LANES(4), .DW(8), .ACC_W(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_signed(b_in_signed), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_acc(b_out_acc), .out_sat(b_out_sat)
  );

  typedef struct { logic [31:0] acc; logic sat; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int e0, input int e1, input int e2, input int e3);
    return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  task automatic push(input bit sel, input logic [31:0] acc, input logic sat);
    exp_t e;
    e.acc = acc;
    e.sat = sat;
    if (sel) qb.push_back(e); else qa.push_back(e);
  endtask

  task automatic send(input bit sel, input logic [31:0] a, input logic [31:0] b,
                      input logic sgn, input logic last);
    bit done = 1'b0;
    int n = 0;
    if (sel) begin
      b_in_a = a; b_in_b = b; b_in_signed = sgn; b_in_last = last; b_in_valid = 1'b1;
    end else begin
      a_in_a = a; a_in_b = b; a_in_signed = sgn; a_in_last = last; a_in_valid = 1'b1;
    end
    while (!done) begin
      @(negedge clk);
      done = sel ? b_in_ready : a_in_ready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        n_vec++; n_bad++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", n);
        break;
      end
    end
    if (sel) b_in_valid = 1'b0; else a_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL a_unexpected: got result %0d, expected no result", a_out_acc);
      end else begin
        ea = qa.pop_front();
        check("a_acc", a_out_acc, ea.acc);
        check("a_sat", {31'd0, a_out_sat}, {31'd0, ea.sat});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL b_unexpected: got result %0d, expected no result", b_out_acc);
      end else begin
        eb = qb.pop_front();
        check("b_acc", {14'd0, b_out_acc}, eb.acc);
        check("b_sat", {31'd0, b_out_sat}, {31'd0, eb.sat});
      end
    end
  end

  initial begin
    a_in_valid = 0; a_in_signed = 0; a_in_last = 0; a_in_a = 0; a_in_b = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_signed = 0; b_in_last = 0; b_in_a = 0; b_in_b = 0; b_out_ready = 1;
    rst_n = 0;
    idle(3);
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_out_acc", a_out_acc, 32'd0);
    check("rst_out_sat", {31'd0, a_out_sat}, 32'd0);
    check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    rst_n = 1;
    idle(1);

    // Unsigned single beat, latency check
    push(0, 32'd70, 1'b0);
    send(0, pk(1,2,3,4), pk(5,6,7,8), 1'b0, 1'b1);
    idle(1);
    check("t1_valid_t+2", {31'd0, a_out_valid}, 32'd0);
    idle(1);
    check("t1_valid_t+3", {31'd0, a_out_valid}, 32'd1);
    idle(3);

    // Signed 3-beat; later in_signed=0 ignored
    push(0, 32'd196608, 1'b0);
    send(0, pk(-128,-128,-128,-128), pk(-128,-128,-128,-128), 1'b1, 1'b0);
    send(0, pk(-128,-128,-128,-128), pk(-128,-128,-128,-128), 1'b0, 1'b0);
    send(0, pk(-128,-128,-128,-128), pk(-128,-128,-128,-128), 1'b0, 1'b1);
    // Signed negative result with a bubble mid-vector; mode must stick
    push(0, 32'hFFFF_FFF0, 1'b0);
    send(0, pk(-1,-1,-1,-1), pk(2,2,2,2), 1'b1, 1'b0);
    idle(2);
    send(0, pk(-1,-1,-1,-1), pk(2,2,2,2), 1'b0, 1'b1);
    push(0, 32'd260100, 1'b0);
    send(0, pk(255,255,255,255), pk(255,255,255,255), 1'b0, 1'b1);
    push(0, 32'd172, 1'b0);
    send(0, pk(-3,5,-7,2), pk(4,-6,-2,100), 1'b1, 1'b1);
    idle(6);

    // Backpressure with two results queued
    a_out_ready = 0;
    push(0, 32'd4, 1'b0);
    send(0, pk(1,1,1,1), pk(1,1,1,1), 1'b0, 1'b1);
    push(0, 32'd24, 1'b0);
    send(0, pk(2,2,2,2), pk(3,3,3,3), 1'b0, 1'b1);
    begin
      int n = 0;
      while (!a_out_valid && n < 20) begin idle(1); n++; end
    end
    repeat (5) begin
      @(negedge clk);
      check("t4_in_ready", {31'd0, a_in_ready}, 32'd0);
      check("t4_hold_acc", a_out_acc, 32'd4);
    end
    @(posedge clk); #1;
    a_out_ready = 1;
    idle(6);

    // Back-to-back single-beat vectors
    fork
      begin
        for (int k = 10; k < 14; k++) begin
          push(0, k, 1'b0);
          send(0, pk(k,0,0,0), pk(1,0,0,0), 1'b0, 1'b1);
        end
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!a_out_valid && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge clk);
          check("t5_valid_run", {31'd0, a_out_valid}, 32'd1);
        end
      end
    join
    idle(6);

    // Reset mid-vector
    send(0, pk(1,1,1,1), pk(100,100,100,100), 1'b0, 1'b0);
    send(0, pk(1,1,1,1), pk(100,100,100,100), 1'b0, 1'b0);
    idle(1);
    rst_n = 0;
    @(negedge clk);
    check("t6_rst_valid", {31'd0, a_out_valid}, 32'd0);
    check("t6_rst_acc", a_out_acc, 32'd0);
    check("t6_rst_sat", {31'd0, a_out_sat}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    idle(1);
    push(0, 32'hFFFF_FFF8, 1'b0);
    send(0, pk(-1,-1,-1,-1), pk(1,1,1,1), 1'b1, 1'b0);
    send(0, pk(-1,-1,-1,-1), pk(1,1,1,1), 1'b0, 1'b1);
    idle(6);

    // 18-bit accumulator: saturation cases
    push(1, 32'd131071, 1'b1);
    repeat (2) send(1, pk(127,127,127,127), pk(127,127,127,127), 1'b1, 1'b0);
    send(1, pk(127,127,127,127), pk(127,127,127,127), 1'b1, 1'b1);
    push(1, 32'd70, 1'b0);
    send(1, pk(1,2,3,4), pk(5,6,7,8), 1'b0, 1'b1);
    push(1, 32'd262143, 1'b1);
    send(1, pk(255,255,255,255), pk(255,255,255,255), 1'b0, 1'b0);
    send(1, pk(255,255,255,255), pk(255,255,255,255), 1'b0, 1'b1);
    push(1, 32'd131072, 1'b1);
    repeat (2) send(1, pk(-128,-128,-128,-128), pk(127,127,127,127), 1'b1, 1'b0);
    send(1, pk(-128,-128,-128,-128), pk(127,127,127,127), 1'b1, 1'b1);
    push(1, 32'd66047, 1'b1);
    repeat (3) send(1, pk(127,127,127,127), pk(127,127,127,127), 1'b1, 1'b0);
    send(1, pk(-128,-128,-128,-128), pk(127,127,127,127), 1'b1, 1'b1);

    begin
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin idle(1); n++; end
    end
    idle(2);
    check("qa_drained", qa.size(), 32'd0);
    check("qb_drained", qb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
